// File: rtl/arcade_input_debouncer_if.sv
// Change-event stream between the input debouncer (master) and its consumer (slave).
// Data layout: {level, 3'b000, index[3:0]}.
interface arcade_input_debouncer_if;
    logic [7:0] evt_data_o;
    logic       evt_valid_o;
    logic       evt_ready_i;

    modport master (
        output evt_data_o,
        output evt_valid_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_data_o,
        input  evt_valid_o,
        output evt_ready_i
    );
endinterface

// File: rtl/arcade_input_debouncer.sv
// Synchronises and debounces raw pad inputs, publishes stable levels and a
// first-word-fall-through FIFO of coalesced per-channel change events.
module arcade_input_debouncer #(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NUM_INPUTS-1:0] raw_i,
    output logic [NUM_INPUTS-1:0] stable_o,
    output logic                  changed_o,
    arcade_input_debouncer_if.master evt
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [NUM_INPUTS-1:0] s1_q;
    logic [NUM_INPUTS-1:0] s2_q;
    logic [NUM_INPUTS-1:0] s1_d;
    logic [NUM_INPUTS-1:0] s2_d;
    logic [NUM_INPUTS-1:0] stable_q;
    logic [NUM_INPUTS-1:0] stable_d;
    logic [NUM_INPUTS-1:0] stable_diff;
    logic                  changed_q;
    logic                  changed_d;
    logic [NUM_INPUTS-1:0] pend_q;
    logic [NUM_INPUTS-1:0] pend_d;

    logic                  sel_valid;
    logic [3:0]            sel_idx;
    logic                  sel_level;
    logic [NUM_INPUTS-1:0] sel_mask;

    logic                  push;
    logic                  pop;
    logic [7:0]            push_data;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [PTR_W:0]        count_q;
    logic [PTR_W:0]        count_d;

    // Two-flop synchroniser; only s2 feeds the debounce logic.
    always_comb begin
        s1_d = raw_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Per-channel counter: counts consecutive cycles s2 disagrees with the
    // stable level; any agreement restarts the attempt.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             lvl_d;

            always_comb begin
                cnt_d = cnt_q;
                lvl_d = stable_q[gi];
                if (s2_q[gi] == stable_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = s2_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = lvl_d;
        end
    endgenerate

    // Lowest pending index wins; the level is sampled now, so repeated
    // toggles while pending collapse into one event with the latest level.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_level = 1'b0;
        sel_mask  = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_valid   = 1'b1;
                sel_idx     = 4'(i);
                sel_level   = stable_q[i];
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        stable_diff = stable_d ^ stable_q;
        changed_d   = |stable_diff;

        // Push decision uses the pre-pop occupancy.
        push      = sel_valid && (count_q < DEPTH_C);
        pop       = (count_q != '0) && evt.evt_ready_i;
        push_data = {sel_level, 3'b000, sel_idx};

        // A fresh change outranks the clear of the event just pushed.
        pend_d = (pend_q & ~(push ? sel_mask : '0)) | stable_diff;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stable_q  <= '0;
            changed_q <= 1'b0;
            pend_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            changed_q <= changed_d;
            pend_q    <= pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign stable_o        = stable_q;
    assign changed_o       = changed_q;
    assign evt.evt_valid_o = (count_q != '0);
    assign evt.evt_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_arcade_input_debouncer.sv
// Bench for arcade_input_debouncer: directed scenarios plus random toggling,
// checked by a scoreboard fed from a behavioural model of the input rules.
module tb_arcade_input_debouncer;

    localparam int NI = 8;
    localparam int DB = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NI-1:0] raw;
    logic [NI-1:0] stable_o;
    logic          changed_o;

    arcade_input_debouncer_if evt_if ();

    arcade_input_debouncer #(
        .NUM_INPUTS     (NI),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (16),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .raw_i    (raw),
        .stable_o (stable_o),
        .changed_o(changed_o),
        .evt      (evt_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [NI-1:0] s1_m    = '0;
    logic [NI-1:0] s2_m    = '0;
    logic [NI-1:0] stab_m  = '0;
    logic [NI-1:0] pend_m  = '0;
    logic          chg_m   = 1'b0;
    int            since_m [NI];
    int            cyc_m   = 0;
    int            fifo_cnt_m = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    log_q [$];
    logic [7:0]    want_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %02h, required %02h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_log(input string name);
        checks++;
        if (log_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL %s: event count %0d, required %0d", name, log_q.size(), want_q.size());
        end
        foreach (want_q[k]) begin
            if (k < log_q.size()) check(name, log_q[k], want_q[k]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a level is accepted once s2 has held a value different from the
    // stable level for DB consecutive samples; events are a set of pending
    // channels drained lowest-first into a bounded queue.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_m = '0; s2_m = '0; stab_m = '0; pend_m = '0; chg_m = 1'b0;
            cyc_m = 0; fifo_cnt_m = 0;
            exp_q.delete();
            for (int i = 0; i < NI; i++) since_m[i] = 0;
        end else begin
            int pre;
            int k;
            logic do_pop;
            logic do_push;
            logic [NI-1:0] new_stab;
            logic [NI-1:0] next_s2;
            pre     = fifo_cnt_m;
            do_pop  = (pre > 0) && evt_if.evt_ready_i;
            do_push = 1'b0;
            if (pend_m != '0 && pre < FD) begin
                k = 0;
                for (int i = NI - 1; i >= 0; i--) if (pend_m[i]) k = i;
                exp_q.push_back({stab_m[k], 3'b000, 4'(k)});
                pend_m[k] = 1'b0;
                do_push   = 1'b1;
            end
            fifo_cnt_m = pre + int'(do_push) - int'(do_pop);

            new_stab = stab_m;
            for (int i = 0; i < NI; i++)
                if (s2_m[i] != stab_m[i] && (cyc_m - since_m[i] + 1) >= DB) new_stab[i] = s2_m[i];
            chg_m  = (new_stab != stab_m);
            pend_m = pend_m | (new_stab ^ stab_m);
            stab_m = new_stab;

            next_s2 = s1_m;
            for (int i = 0; i < NI; i++)
                if (next_s2[i] != s2_m[i]) since_m[i] = cyc_m + 1;
            s2_m  = next_s2;
            s1_m  = raw;
            cyc_m = cyc_m + 1;
        end
    end

    // Monitor: compare on the falling edge, pop the scoreboard on handshake.
    always @(negedge clk) begin
        check("stable", stable_o, stab_m);
        check("changed", {7'b0, changed_o}, {7'b0, chg_m});
        check("valid", {7'b0, evt_if.evt_valid_o}, {7'b0, (fifo_cnt_m != 0)});
        if (evt_if.evt_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt_head: got %02h, required no event (t=%0t)", evt_if.evt_data_o, $time);
            end else begin
                check("evt_head", evt_if.evt_data_o, exp_q[0]);
                if (evt_if.evt_ready_i) begin
                    $display("event popped %02h at t=%0t", evt_if.evt_data_o, $time);
                    log_q.push_back(evt_if.evt_data_o);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int ch;
        rstn = 1'b0;
        raw  = '0;
        evt_if.evt_ready_i = 1'b0;
        tick(3);
        check("rst_stable", stable_o, 8'h00);
        check("rst_valid", {7'b0, evt_if.evt_valid_o}, 8'h00);
        check("rst_changed", {7'b0, changed_o}, 8'h00);
        check("rst_data", evt_if.evt_data_o, 8'h00);
        rstn = 1'b1;
        tick(50);
        check("idle_valid", {7'b0, evt_if.evt_valid_o}, 8'h00);

        // Single rise on channel 2: accepted at E+5.
        raw[2] = 1'b1;
        tick(1);
        tick(4);
        check("scn2_before", {7'b0, stable_o[2]}, 8'h00);
        tick(1);
        check("scn2_stable", {7'b0, stable_o[2]}, 8'h01);
        check("scn2_changed", {7'b0, changed_o}, 8'h01);
        tick(1);
        check("scn2_changed_off", {7'b0, changed_o}, 8'h00);
        check("scn2_valid", {7'b0, evt_if.evt_valid_o}, 8'h01);
        check("scn2_data", evt_if.evt_data_o, 8'h82);
        evt_if.evt_ready_i = 1'b1;
        tick(1);
        check("scn2_popped", {7'b0, evt_if.evt_valid_o}, 8'h00);
        evt_if.evt_ready_i = 1'b0;

        // Short glitch on channel 5 is rejected, then a held level is accepted.
        raw[5] = 1'b1;
        tick(3);
        raw[5] = 1'b0;
        tick(10);
        check("scn3_glitch", stable_o, 8'h04);
        check("scn3_noevt", {7'b0, evt_if.evt_valid_o}, 8'h00);
        raw[5] = 1'b1;
        tick(1);
        tick(4);
        check("scn3_before", {7'b0, stable_o[5]}, 8'h00);
        tick(1);
        check("scn3_stable", {7'b0, stable_o[5]}, 8'h01);
        evt_if.evt_ready_i = 1'b1;
        tick(5);

        // Simultaneous rises drain in ascending index order.
        log_q.delete();
        raw = raw | 8'h89;
        tick(15);
        want_q = '{8'h80, 8'h83, 8'h87};
        check_log("scn4_order");

        // Fill the FIFO while blocked; two channels wait in the pending mask.
        raw = '0;
        tick(25);
        log_q.delete();
        evt_if.evt_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            raw[c] = 1'b1;
            tick(8);
        end
        tick(10);
        check("scn5_valid", {7'b0, evt_if.evt_valid_o}, 8'h01);
        check("scn5_head", evt_if.evt_data_o, 8'h80);
        evt_if.evt_ready_i = 1'b1;
        tick(12);
        want_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
        check_log("scn5_order");

        // Channel 1 goes 1 then 0 while blocked: one coalesced event.
        raw = '0;
        tick(25);
        log_q.delete();
        evt_if.evt_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c != 1) begin
                raw[c] = 1'b1;
                tick(8);
            end
        end
        raw[1] = 1'b1;
        tick(10);
        raw[1] = 1'b0;
        tick(10);
        check("scn6_stable", stable_o, 8'h1D);
        evt_if.evt_ready_i = 1'b1;
        tick(15);
        want_q = '{8'h80, 8'h82, 8'h83, 8'h84, 8'h01};
        check_log("scn6_coalesce");

        // Asynchronous reset mid-debounce with a non-empty FIFO.
        evt_if.evt_ready_i = 1'b0;
        raw[5] = 1'b1;
        tick(8);
        check("scn6_pre_valid", {7'b0, evt_if.evt_valid_o}, 8'h01);
        raw[6] = 1'b1;
        tick(3);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", {7'b0, evt_if.evt_valid_o}, 8'h00);
        check("arst_stable", stable_o, 8'h00);
        check("arst_changed", {7'b0, changed_o}, 8'h00);
        check("arst_data", evt_if.evt_data_o, 8'h00);
        tick(2);
        rstn = 1'b1;

        // Random bouncing inputs and consumer back-pressure.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch = int'($urandom_range(0, NI - 1));
                raw[ch] = ~raw[ch];
            end
            evt_if.evt_ready_i = ($urandom_range(0, 2) != 0);
            if (c == 1500) begin
                rstn = 1'b0;
                tick(2);
                rstn = 1'b1;
            end
            tick(1);
        end
        evt_if.evt_ready_i = 1'b1;
        tick(40);
        check("final_drained", 8'(exp_q.size()), 8'h00);
        check("final_valid", {7'b0, evt_if.evt_valid_o}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arcade_input_debouncer.md
Name: arcade_input_debouncer

Overview:
Conditioning stage placed directly upstream of arcade_io_device. It feeds that device's inputs_i with clean, stable button/joystick levels.
- Synchronises NUM_INPUTS raw pad inputs into clk_i and debounces each one independently.
- Publishes stable levels plus a queued change-event stream, so the device can report edges without missing or duplicating them.
- Runs on the 48MHz application clock.

Parameters:
NUM_INPUTS, 8, number of raw inputs; legal range 1..16.
DEBOUNCE_CYCLES, 48000, consecutive cycles a synchronised level must differ from the stable level before it is accepted (1ms at 48MHz); legal range 2..65535.
CNT_W, 16, width of each per-channel debounce counter; must hold DEBOUNCE_CYCLES-1.
FIFO_DEPTH, 4, change-event FIFO entries; power of two, 2..16.

Ports:
clk_i  in  1  application clock, 48MHz
rstn_i  in  1  reset, asynchronous assert, active-low
raw_i  in  NUM_INPUTS  raw asynchronous inputs, active-high
stable_o  out  NUM_INPUTS  debounced levels, registered; connects to inputs_i
changed_o  out  1  one-cycle pulse when any stable_o bit changes
evt_data_o  out  8  {level[7], 3'b000, index[3:0]}, head of event FIFO
evt_valid_o  out  1  FIFO not empty
evt_ready_i  in  1  consumer pops head when evt_valid_o & evt_ready_i

Behaviour:
Reset (rstn_i low, any time, including mid-debounce or with a non-empty FIFO): all state clears immediately.
- Sync flops, counters, stable_o = 0, pending mask = 0, FIFO empty.
- evt_valid_o = 0, evt_data_o = 0, changed_o = 0.
- No events are generated for inputs already low at reset release.

Synchroniser: two flops per bit (s1 <= raw_i, s2 <= s1). Only s2 is used downstream.

Debounce, per channel i:
- If s2[i] == stable_o[i], cnt[i] <= 0.
- Else if cnt[i] == DEBOUNCE_CYCLES-1, stable_o[i] <= s2[i] and cnt[i] <= 0.
- Else cnt[i] <= cnt[i]+1.
- Latency: a raw change first captured by s1 at edge E appears on stable_o at edge E+DEBOUNCE_CYCLES+1, provided it is held.
- Any return of s2 to the stable level before then discards the attempt; the counter restarts from 0.

changed_o: registered, high for exactly the cycle after any stable_o bit updates.

Pending mask:
- pend[i] sets on the edge stable_o[i] changes.
- Set has priority over clear in the same cycle.

Arbiter / push:
- Each cycle, select the lowest index i with pend[i]=1.
- Push {stable_o[i], 3'b0, i} when FIFO count (before any pop this cycle) < FIFO_DEPTH, and clear pend[i].
- At most one push per cycle. Simultaneous changes drain in ascending index order over consecutive cycles.
- If channel i toggles again while pending, no second event is generated. The pushed event carries the level current at push time (coalesced). Events are never lost.
- FIFO full: no push; pend bits hold until space frees. A pop in the same cycle does not enable a push (push uses the pre-pop count).

FIFO:
- First-word-fall-through: evt_data_o shows the head whenever evt_valid_o=1.
- Pop on evt_valid_o & evt_ready_i.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- evt_data_o holds its last value (don't-care) when empty; the bench checks data only while valid.

Widths: index field is zero-extended to 4 bits. Counter comparisons are unsigned.

Test Plan:
DEBOUNCE_CYCLES=4, FIFO_DEPTH=4 for all scenarios.
1. Reset -> stable_o=0, evt_valid_o=0, changed_o=0; raw_i held 0 for 50 cycles -> no events.
2. raw_i[2] 0->1 captured at edge E and held -> stable_o[2]=1 at edge E+5; changed_o high one cycle; evt_data_o=8'h82 valid; pop -> evt_valid_o=0.
3. raw_i[5] pulses high for 3 cycles -> stable_o unchanged, no event; then held 1 -> accepted exactly 4 cycles after s2 rises.
4. raw_i[0], raw_i[3], raw_i[7] rise together, evt_ready_i=1 -> events 8'h80, 8'h83, 8'h87 on consecutive cycles, in order.
5. evt_ready_i=0; toggle channels 0..5 individually to 1 -> FIFO holds 80,81,82,83; evt_valid_o stays 1; channels 4,5 pending; release ready -> 84, 85 follow; nothing lost or duplicated.
6. Channel 1 goes stable 1 then stable 0 while blocked by a full FIFO -> exactly one event 8'h01 after drain. Assert rstn_i low mid-debounce with FIFO non-empty -> FIFO empty, stable_o=0 on the same cycle.
